// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, decoder and execute-stage redirect.
// The master side is the fetch unit; the slave side is everything around it.
interface instruction_fetch_unit_if #(
    parameter int unsigned Aw = 8,
    parameter int unsigned Dw = 16
);
    logic [Aw-1:0] im_addr;
    logic [Dw-1:0] im_rd;
    logic [Dw-1:0] ir;
    logic [Aw-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;
    logic          redir_valid;
    logic [Aw-1:0] redir_addr;

    modport master (
        output im_addr,
        input  im_rd,
        output ir,
        output ir_pc,
        output ir_valid,
        input  ir_ready,
        input  redir_valid,
        input  redir_addr
    );

    modport slave (
        input  im_addr,
        output im_rd,
        input  ir,
        input  ir_pc,
        input  ir_valid,
        output ir_ready,
        output redir_valid,
        output redir_addr
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, resolves JUMP locally, takes execute redirects and hands
// instructions to the decoder over a valid/ready handshake (one instruction per two cycles peak).
module instruction_fetch_unit #(
    parameter int unsigned Aw      = 8,
    parameter int unsigned Dw      = 16,
    parameter int unsigned ProgLen = 22,
    parameter logic [4:0]  JumpOp  = 5'b00101,
    parameter int unsigned ResetPc = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    instruction_fetch_unit_if.master  bus_io,
    output logic                      busy_o,
    output logic                      halted_o,
    output logic                      fault_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StIssue = 2'd2;
    localparam logic [1:0] StHalt  = 2'd3;

    localparam logic [Aw-1:0] PcReset   = ResetPc[Aw-1:0];
    localparam logic [Aw:0]   ProgLimit = ProgLen[Aw:0];
    localparam logic [Aw-1:0] PcOne     = {{(Aw-1){1'b0}}, 1'b1};

    logic [1:0]    state_q, state_d;
    logic [Aw-1:0] pc_q, pc_d;
    logic [Dw-1:0] ir_q, ir_d;
    logic [Aw-1:0] ir_pc_q, ir_pc_d;
    logic          ir_valid_q, ir_valid_d;
    logic          fault_q, fault_d;

    logic          is_jump;
    logic [Aw-1:0] jump_target;
    logic          jump_in_range;
    logic          redir_in_range;
    logic          pc_in_range;
    logic          accept;

    assign is_jump        = (bus_io.im_rd[Dw-1:Dw-5] == JumpOp);
    assign jump_target    = bus_io.im_rd[Aw-1:0];
    assign jump_in_range  = ({1'b0, jump_target} < ProgLimit);
    assign redir_in_range = ({1'b0, bus_io.redir_addr} < ProgLimit);
    assign pc_in_range    = ({1'b0, pc_q} < ProgLimit);
    assign accept         = ir_valid_q & bus_io.ir_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        fault_d    = fault_q;

        case (state_q)
            StIdle, StHalt: begin
                ir_valid_d = 1'b0;
                if (start_i) begin
                    state_d = StFetch;
                    pc_d    = PcReset;
                    fault_d = 1'b0;
                end
            end

            StFetch, StIssue: begin
                // Redirect overrides jump, fetch and handshake, and flushes any unaccepted IR.
                if (bus_io.redir_valid) begin
                    ir_valid_d = 1'b0;
                    pc_d       = bus_io.redir_addr;
                    if (redir_in_range) begin
                        state_d = StFetch;
                    end else begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end
                end else if (state_q == StFetch) begin
                    if (is_jump) begin
                        pc_d = jump_target;
                        if (!jump_in_range) begin
                            state_d = StHalt;
                            fault_d = 1'b1;
                        end
                    end else begin
                        ir_d       = bus_io.im_rd;
                        ir_pc_d    = pc_q;
                        ir_valid_d = 1'b1;
                        pc_d       = pc_q + PcOne;
                        state_d    = StIssue;
                    end
                end else if (accept) begin
                    ir_valid_d = 1'b0;
                    state_d    = pc_in_range ? StFetch : StHalt;
                end
            end

            default: begin
                state_d    = StIdle;
                ir_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            pc_q       <= PcReset;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            fault_q    <= fault_d;
        end
    end

    assign bus_io.im_addr  = pc_q;
    assign bus_io.ir       = ir_q;
    assign bus_io.ir_pc    = ir_pc_q;
    assign bus_io.ir_valid = ir_valid_q;

    assign busy_o   = (state_q == StFetch) || (state_q == StIssue);
    assign halted_o = (state_q == StHalt);
    assign fault_o  = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential issue, stall, local jump, redirect,
// out-of-range fault and reset mid-handshake, against a negedge-latching memory model.
module tb_instruction_fetch_unit;

    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic halted;
    logic fault;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mem [0:255];
    logic [7:0]  issued [0:63];
    int          n_issued;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .bus_io   (bus),
        .busy_o   (busy),
        .halted_o (halted),
        .fault_o  (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory latches the address on negedge; data is ready for the following posedge.
    always @(negedge clk) bus.im_rd <= mem[bus.im_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h0100 + 16'(a);
        mem[19] = 16'h2815;  // JUMP to 21
        bus.im_rd       = '0;
        bus.ir_ready    = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_addr  = '0;
        start = 1'b0;
        rst_n = 1'b0;
        step();
        step();

        check_eq("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_im_addr", 32'(bus.im_addr), 32'd0);

        // Start and first issue, then stall for five cycles
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("fetch0_busy", 32'(busy), 32'd1);
        check_eq("fetch0_addr", 32'(bus.im_addr), 32'd0);
        check_eq("fetch0_valid", 32'(bus.ir_valid), 32'd0);
        step();
        for (int c = 0; c < 5; c++) begin
            check_eq("stall_valid", 32'(bus.ir_valid), 32'd1);
            check_eq("stall_ir_pc", 32'(bus.ir_pc), 32'd0);
            check_eq("stall_ir", 32'(bus.ir), 32'h0100);
            check_eq("stall_addr", 32'(bus.im_addr), 32'd1);
            step();
        end

        // Release: accept 0, then issue 1 and 2 on alternate cycles
        bus.ir_ready = 1'b1;
        step();
        check_eq("acc0_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("fetch1_addr", 32'(bus.im_addr), 32'd1);
        step();
        check_eq("issue1_pc", 32'(bus.ir_pc), 32'd1);
        check_eq("issue1_valid", 32'(bus.ir_valid), 32'd1);
        step();
        check_eq("fetch2_addr", 32'(bus.im_addr), 32'd2);
        check_eq("fetch2_valid", 32'(bus.ir_valid), 32'd0);
        step();
        check_eq("issue2_pc", 32'(bus.ir_pc), 32'd2);
        check_eq("issue2_ir", 32'(bus.ir), 32'h0102);
        step();
        check_eq("fetch3_addr", 32'(bus.im_addr), 32'd3);

        // Run to the end: 19 jumps to 21, 20 is skipped, accepting 21 halts
        n_issued = 0;
        for (int c = 0; c < 200; c++) begin
            if (halted) break;
            if (bus.ir_valid && n_issued < 64) begin
                issued[n_issued] = bus.ir_pc;
                n_issued++;
            end
            step();
        end
        check_eq("run_halted", 32'(halted), 32'd1);
        check_eq("run_fault", 32'(fault), 32'd0);
        check_eq("run_count", 32'(n_issued), 32'd17);
        for (int k = 0; k < n_issued && k < 17; k++) begin
            check_eq("run_seq", 32'(issued[k]), (k < 16) ? 32'(3 + k) : 32'd21);
        end

        // Redirect to 9, then redirect to 5 while 9 is unaccepted (with ready high)
        bus.ir_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        bus.redir_valid = 1'b1;
        bus.redir_addr  = 8'd9;
        step();
        check_eq("redir9_addr", 32'(bus.im_addr), 32'd9);
        bus.redir_valid = 1'b0;
        step();
        check_eq("issue9_pc", 32'(bus.ir_pc), 32'd9);
        check_eq("issue9_ir", 32'(bus.ir), 32'h0109);
        check_eq("issue9_valid", 32'(bus.ir_valid), 32'd1);
        bus.redir_valid = 1'b1;
        bus.redir_addr  = 8'd5;
        bus.ir_ready    = 1'b1;
        step();
        check_eq("flush_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("flush_addr", 32'(bus.im_addr), 32'd5);
        check_eq("flush_busy", 32'(busy), 32'd1);
        bus.redir_valid = 1'b0;
        bus.ir_ready    = 1'b0;
        step();
        check_eq("issue5_pc", 32'(bus.ir_pc), 32'd5);
        check_eq("issue5_valid", 32'(bus.ir_valid), 32'd1);

        // Out-of-range redirect faults; a redirect in HALT is ignored
        bus.redir_valid = 1'b1;
        bus.redir_addr  = 8'd30;
        step();
        check_eq("redir_oor_fault", 32'(fault), 32'd1);
        check_eq("redir_oor_halt", 32'(halted), 32'd1);
        check_eq("redir_oor_valid", 32'(bus.ir_valid), 32'd0);
        bus.redir_addr = 8'd3;
        step();
        check_eq("halt_redir_ign", 32'(halted), 32'd1);
        bus.redir_valid = 1'b0;

        // Jump out of range at address 0
        mem[0] = 16'h2830;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("restart_fault_clr", 32'(fault), 32'd0);
        step();
        check_eq("jump_oor_fault", 32'(fault), 32'd1);
        check_eq("jump_oor_halt", 32'(halted), 32'd1);
        check_eq("jump_oor_valid", 32'(bus.ir_valid), 32'd0);
        mem[0] = 16'h0100;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("resume_fault", 32'(fault), 32'd0);
        check_eq("resume_addr", 32'(bus.im_addr), 32'd0);
        step();
        check_eq("resume_pc", 32'(bus.ir_pc), 32'd0);
        check_eq("resume_valid", 32'(bus.ir_valid), 32'd1);

        // Reset mid-ISSUE with START held
        rst_n = 1'b0;
        start = 1'b1;
        step();
        check_eq("midrst_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_halted", 32'(halted), 32'd0);
        check_eq("midrst_addr", 32'(bus.im_addr), 32'd0);
        check_eq("midrst_ir", 32'(bus.ir), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        step();
        check_eq("post_rst_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
